// File: rtl/lcd_frame_scheduler.sv
// Frame-level pixel source scheduler for the LCD: owns the scan position,
// switches source only between frames and covers camera starvation with black.
module lcd_frame_scheduler #(
  parameter int H_PIXELS      = 320,
  parameter int V_PIXELS      = 240,
  parameter int STALL_TIMEOUT = 4096
) (
  input  logic        clk_100MHz,
  input  logic        rst,
  input  logic        req_cam,
  input  logic        req_colour,
  input  logic [15:0] pix_cube,
  input  logic [15:0] pix_colour,
  input  logic [15:0] pix_cam,
  input  logic        cam_avail,
  input  logic        pix_take,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  output logic        cam_read,
  output logic [8:0]  x,
  output logic [7:0]  y,
  output logic [1:0]  src,
  output logic        frame_start,
  output logic        frame_done,
  output logic        underrun,
  output logic [1:0]  fsm_state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_START  = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_END    = 2'd3;

  localparam logic [1:0] SRC_CUBE   = 2'd0;
  localparam logic [1:0] SRC_COLOUR = 2'd1;
  localparam logic [1:0] SRC_CAM    = 2'd2;

  localparam logic [8:0] X_LAST = 9'(H_PIXELS - 1);
  localparam logic [7:0] Y_LAST = 8'(V_PIXELS - 1);

  localparam int CW = $clog2(STALL_TIMEOUT + 1);
  localparam logic [CW-1:0] STALL_MAX = CW'(STALL_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic [1:0]    state;
  logic [CW-1:0] stall_cnt;
  logic          starve;
  logic          take_ok;

  assign fsm_state = state;

  // Handshake: pix_data is held while pix_valid=1; a pix_take pulse in a cycle
  // with pix_valid=1 consumes that pixel, any other pix_take is ignored.
  always_comb begin
    pix_data    = 16'h0000;
    pix_valid   = 1'b0;
    cam_read    = 1'b0;
    starve      = (state == S_STREAM) && (src == SRC_CAM) && (stall_cnt == STALL_MAX);
    frame_start = (state == S_START);
    frame_done  = (state == S_END);
    if (state == S_STREAM) begin
      case (src)
        SRC_CUBE: begin
          pix_valid = 1'b1;
          pix_data  = pix_cube;
        end
        SRC_COLOUR: begin
          pix_valid = 1'b1;
          pix_data  = pix_colour;
        end
        SRC_CAM: begin
          if (starve) begin
            pix_valid = 1'b1;
          end else begin
            pix_valid = cam_avail;
            pix_data  = pix_cam;
            cam_read  = pix_take & cam_avail;
          end
        end
        default: ;
      endcase
    end
    take_ok = pix_take & pix_valid;
  end

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      state     <= S_IDLE;
      x         <= 9'd0;
      y         <= 8'd0;
      src       <= SRC_CUBE;
      stall_cnt <= '0;
      underrun  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: state <= S_START;
        S_START: begin
          x         <= 9'd0;
          y         <= 8'd0;
          stall_cnt <= '0;
          src       <= req_cam ? SRC_CAM : (req_colour ? SRC_COLOUR : SRC_CUBE);
          state     <= S_STREAM;
        end
        S_STREAM: begin
          if (take_ok) begin
            stall_cnt <= '0;
            // Last pixel leaves the position in place; END clears it.
            if (x == X_LAST && y == Y_LAST) begin
              state <= S_END;
            end else if (y == Y_LAST) begin
              y <= 8'd0;
              x <= x + 9'd1;
            end else begin
              y <= y + 8'd1;
            end
          end else if (src == SRC_CAM && !starve) begin
            stall_cnt <= cam_avail ? '0 : stall_cnt + CNT_ONE;
          end
          if (starve) underrun <= 1'b1;
        end
        S_END: begin
          x     <= 9'd0;
          y     <= 8'd0;
          state <= S_START;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_frame_scheduler.sv
// Directed bench for lcd_frame_scheduler on a small 6x4 panel with a short
// starvation timeout; a scan-order scoreboard checks every accepted pixel.
module tb_lcd_frame_scheduler;

  localparam int H  = 6;
  localparam int V  = 4;
  localparam int ST = 8;

  localparam logic [15:0] CUBE_PIX   = 16'hC0BE;
  localparam logic [15:0] COLOUR_PIX = 16'h5A5A;
  localparam logic [15:0] CAM_PIX    = 16'hCA11;

  logic        clk_100MHz = 1'b0;
  logic        rst;
  logic        req_cam, req_colour;
  logic [15:0] pix_cube, pix_colour, pix_cam;
  logic        cam_avail, pix_take;
  logic [15:0] pix_data;
  logic        pix_valid, cam_read;
  logic [8:0]  x;
  logic [7:0]  y;
  logic [1:0]  src;
  logic        frame_start, frame_done, underrun;
  logic [1:0]  fsm_state;

  int n_checks = 0;
  int n_errors = 0;
  int n_takes  = 0;
  int n_reads  = 0;
  bit sb_en    = 1'b0;
  int cyc;
  int n;

  logic [32:0] exp_q[$];

  lcd_frame_scheduler #(.H_PIXELS(H), .V_PIXELS(V), .STALL_TIMEOUT(ST)) dut (
    .clk_100MHz (clk_100MHz),
    .rst        (rst),
    .req_cam    (req_cam),
    .req_colour (req_colour),
    .pix_cube   (pix_cube),
    .pix_colour (pix_colour),
    .pix_cam    (pix_cam),
    .cam_avail  (cam_avail),
    .pix_take   (pix_take),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .cam_read   (cam_read),
    .x          (x),
    .y          (y),
    .src        (src),
    .frame_start(frame_start),
    .frame_done (frame_done),
    .underrun   (underrun),
    .fsm_state  (fsm_state)
  );

  // clock/reset
  always #5 clk_100MHz = ~clk_100MHz;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: expected {pix_data, x, y} for each accepted take, in scan order
  task automatic load_sb(input logic [15:0] data);
    exp_q.delete();
    for (int xi = 0; xi < H; xi++)
      for (int yi = 0; yi < V; yi++)
        exp_q.push_back({data, 9'(xi), 8'(yi)});
    n_takes = 0;
    n_reads = 0;
  endtask

  always @(negedge clk_100MHz) begin
    if (!rst && cam_read) n_reads++;
    if (!rst && pix_take && pix_valid) begin
      n_takes++;
      if (sb_en) begin
        if (exp_q.size() == 0) begin
          check_val("sb_extra_take", {pix_data, x, y}, 33'd0);
        end else begin
          check_val("sb_pixel", {pix_data, x, y}, exp_q.pop_front());
        end
      end
    end
  end

  // drivers
  task automatic tick();
    @(posedge clk_100MHz);
    #2;
  endtask

  task automatic run_to_done(input int budget, input bit toggle, input int colour_at,
                             output int cycles);
    cycles = 0;
    while (!frame_done && cycles < budget) begin
      if (toggle) cam_avail = cycles[0];
      if (colour_at >= 0 && n_takes == colour_at) req_colour = 1'b1;
      tick();
      cycles++;
    end
    check_val("frame_done_seen", {63'd0, frame_done}, 64'd1);
  endtask

  initial begin
    rst = 1'b1; req_cam = 1'b0; req_colour = 1'b0;
    pix_cube = CUBE_PIX; pix_colour = COLOUR_PIX; pix_cam = CAM_PIX;
    cam_avail = 1'b0; pix_take = 1'b0;
    repeat (3) tick();
    check_val("rst_state", fsm_state, 0);
    check_val("rst_pos", {x, y}, 0);
    check_val("rst_src", src, 0);
    check_val("rst_flags", {frame_start, frame_done, underrun, pix_valid, cam_read}, 0);

    // cube frame, take every cycle, colour requested mid-frame
    rst = 1'b0;
    #1;
    check_val("idle_after_rst", fsm_state, 0);
    check_val("no_start_yet", frame_start, 0);
    tick();
    check_val("start_pulse", frame_start, 1);
    check_val("start_pos", {x, y}, 0);
    pix_take = 1'b1;
    #1;
    check_val("start_not_valid", pix_valid, 0);
    load_sb(CUBE_PIX);
    sb_en = 1'b1;
    tick();
    check_val("cube_src", src, 0);
    check_val("stream_state", fsm_state, 2);
    run_to_done(200, 1'b0, 10, cyc);
    check_val("cube_frame_len", cyc, H * V);
    check_val("cube_takes", n_takes, H * V);
    check_val("cube_sb_empty", exp_q.size(), 0);
    check_val("src_held_mid_frame", src, 0);
    check_val("end_pos_held", {x, y}, {9'd5, 8'd3});
    check_val("end_not_valid", pix_valid, 0);
    tick();
    check_val("restart_pulse", frame_start, 1);
    check_val("restart_pos", {x, y}, 0);
    check_val("end_take_ignored", n_takes, H * V);

    // colour frame
    load_sb(COLOUR_PIX);
    tick();
    check_val("colour_src", src, 1);
    check_val("colour_data", pix_data, COLOUR_PIX);
    req_cam = 1'b1;
    run_to_done(200, 1'b0, -1, cyc);
    check_val("colour_takes", n_takes, H * V);
    check_val("colour_sb_empty", exp_q.size(), 0);
    check_val("colour_src_held", src, 1);

    // camera frame, cam_avail toggling each cycle
    tick();
    load_sb(CAM_PIX);
    tick();
    check_val("cam_src_priority", src, 2);
    run_to_done(200, 1'b1, -1, cyc);
    check_val("cam_toggle_len", cyc, 2 * H * V);
    check_val("cam_toggle_takes", n_takes, H * V);
    check_val("cam_toggle_reads", n_reads, H * V);
    check_val("cam_sb_empty", exp_q.size(), 0);

    // camera starvation
    cam_avail = 1'b0;
    sb_en = 1'b0;
    n_takes = 0;
    n_reads = 0;
    tick();
    tick();
    check_val("starve_src", src, 2);
    check_val("underrun_clear", underrun, 0);
    repeat (4) tick();
    check_val("invalid_take_no_move", {x, y}, 0);
    check_val("invalid_take_no_read", n_reads, 0);
    pix_take = 1'b0;
    repeat (2) tick();
    #1;
    check_val("stall_before_timeout", pix_valid, 0);
    tick();
    check_val("stall_valid", pix_valid, 1);
    check_val("stall_black", pix_data, 0);
    tick();
    check_val("stall_valid_held", pix_valid, 1);
    check_val("underrun_set", underrun, 1);
    cam_avail = 1'b1;
    #1;
    check_val("black_held_until_take", pix_data, 0);
    cam_avail = 1'b0;
    pix_take = 1'b1;
    #1;
    check_val("black_take_no_read", cam_read, 0);
    tick();
    check_val("black_take_pos", {x, y}, {9'd0, 8'd1});
    check_val("stall_cleared", pix_valid, 0);
    cam_avail = 1'b1;
    run_to_done(200, 1'b0, -1, cyc);
    check_val("starve_takes", n_takes, H * V);
    check_val("starve_reads", n_reads, H * V - 1);

    // cube frame: row wrap, then reset mid-frame
    req_cam = 1'b0;
    req_colour = 1'b0;
    cam_avail = 1'b0;
    tick();
    check_val("underrun_sticky", underrun, 1);
    load_sb(CUBE_PIX);
    sb_en = 1'b1;
    tick();
    check_val("cube_again_src", src, 0);
    n = 0;
    while (!(x == 9'd1 && y == 8'd3) && n < 50) begin tick(); n++; end
    check_val("reach_wrap_point", {x, y}, {9'd1, 8'd3});
    tick();
    check_val("wrap_pos", {x, y}, {9'd2, 8'd0});
    n = 0;
    while (!(x == 9'd3 && y == 8'd2) && n < 50) begin tick(); n++; end
    check_val("reach_rst_point", {x, y}, {9'd3, 8'd2});
    rst = 1'b1;
    sb_en = 1'b0;
    tick();
    check_val("midrst_state", fsm_state, 0);
    check_val("midrst_pos", {x, y}, 0);
    check_val("midrst_flags", {frame_start, frame_done, underrun, pix_valid, cam_read, src}, 0);
    tick();
    check_val("midrst_no_done", frame_done, 0);
    rst = 1'b0;
    pix_take = 1'b0;
    #1;
    check_val("midrst_idle", fsm_state, 0);
    tick();
    check_val("midrst_restart", frame_start, 1);
    check_val("midrst_restart_pos", {x, y}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
